// File: rtl/pool_window_addr_gen.sv
// Pooling-window read-address generator: walks a CHANNELS x IMG_H x IMG_W buffer
// and presents all WIN*WIN addresses of one window per accepted beat.
module pool_window_addr_gen #(
    parameter int IMG_W    = 24,
    parameter int IMG_H    = 24,
    parameter int WIN      = 2,
    parameter int STRIDE   = 2,
    parameter int CHANNELS = 1,
    parameter int LEAD_IN  = 0,
    parameter int ADDR_W   = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       clear,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [WIN*WIN*ADDR_W-1:0]  addr,
    output logic [7:0]                 out_x,
    output logic [7:0]                 out_y,
    output logic [7:0]                 out_ch,
    output logic                       last,
    output logic                       done
);

    localparam int OUT_W = (IMG_W - WIN) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - WIN) / STRIDE + 1;
    localparam int NWIN  = OUT_W * OUT_H * CHANNELS;

    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE * IMG_W);
    localparam logic [ADDR_W-1:0] CH_STEP  = ADDR_W'(IMG_W * IMG_H);
    localparam logic [7:0]        X_MAX    = 8'(OUT_W - 1);
    localparam logic [7:0]        Y_MAX    = 8'(OUT_H - 1);
    localparam logic [7:0]        CH_MAX   = 8'(CHANNELS - 1);
    localparam logic [7:0]        LEAD_LEN = 8'(LEAD_IN);
    localparam logic              IS_SINGLE = (NWIN == 1);

    generate
        if (2**ADDR_W < CHANNELS * IMG_W * IMG_H) begin : g_addr_w_check
            $error("pool_window_addr_gen: ADDR_W too small for the feature-map buffer");
        end
        if (WIN < 1 || WIN > 4 || STRIDE < 1 || STRIDE > WIN) begin : g_win_check
            $error("pool_window_addr_gen: WIN/STRIDE out of range");
        end
        if (LEAD_IN < 0 || LEAD_IN > 255) begin : g_lead_check
            $error("pool_window_addr_gen: LEAD_IN out of range");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_RUN, S_DONE} state_t;

    state_t             state_reg, state_next;
    logic [7:0]         lead_cnt_reg, lead_cnt_next;
    logic [7:0]         x_reg, x_next;
    logic [7:0]         y_reg, y_next;
    logic [7:0]         ch_reg, ch_next;
    logic [ADDR_W-1:0]  win_base_reg, win_base_next;
    logic [ADDR_W-1:0]  row_base_reg, row_base_next;
    logic [ADDR_W-1:0]  ch_base_reg, ch_base_next;
    logic               valid_reg, valid_next;
    logic               last_reg, last_next;
    logic               done_reg, done_next;
    logic               load_first;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            lead_cnt_reg <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            ch_reg       <= '0;
            win_base_reg <= '0;
            row_base_reg <= '0;
            ch_base_reg  <= '0;
            valid_reg    <= 1'b0;
            last_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lead_cnt_reg <= lead_cnt_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            ch_reg       <= ch_next;
            win_base_reg <= win_base_next;
            row_base_reg <= row_base_next;
            ch_base_reg  <= ch_base_next;
            valid_reg    <= valid_next;
            last_reg     <= last_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        lead_cnt_next = lead_cnt_reg;
        x_next        = x_reg;
        y_next        = y_reg;
        ch_next       = ch_reg;
        win_base_next = win_base_reg;
        row_base_next = row_base_reg;
        ch_base_next  = ch_base_reg;
        valid_next    = valid_reg;
        last_next     = last_reg;
        done_next     = done_reg;
        load_first    = 1'b0;

        if (clear) begin
            state_next = S_IDLE;
            valid_next = 1'b0;
            last_next  = 1'b0;
            done_next  = 1'b0;
            load_first = 1'b1;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        load_first = 1'b1;
                        done_next  = 1'b0;
                        if (LEAD_IN > 0) begin
                            state_next    = S_LEAD;
                            lead_cnt_next = 8'd1;
                        end else begin
                            state_next = S_RUN;
                            valid_next = 1'b1;
                            last_next  = IS_SINGLE;
                        end
                    end
                end
                S_LEAD: begin
                    // counter holds the number of edges already spent in LEAD
                    if (lead_cnt_reg == LEAD_LEN) begin
                        state_next = S_RUN;
                        valid_next = 1'b1;
                        last_next  = IS_SINGLE;
                    end else begin
                        lead_cnt_next = lead_cnt_reg + 8'd1;
                    end
                end
                S_RUN: begin
                    if (out_ready) begin
                        if (last_reg) begin
                            state_next = S_DONE;
                            valid_next = 1'b0;
                            last_next  = 1'b0;
                            done_next  = 1'b1;
                            load_first = 1'b1;
                        end else begin
                            if (x_reg != X_MAX) begin
                                x_next        = x_reg + 8'd1;
                                win_base_next = win_base_reg + COL_STEP;
                            end else if (y_reg != Y_MAX) begin
                                x_next        = '0;
                                y_next        = y_reg + 8'd1;
                                row_base_next = row_base_reg + ROW_STEP;
                                win_base_next = row_base_reg + ROW_STEP;
                            end else begin
                                x_next        = '0;
                                y_next        = '0;
                                ch_next       = ch_reg + 8'd1;
                                ch_base_next  = ch_base_reg + CH_STEP;
                                row_base_next = ch_base_reg + CH_STEP;
                                win_base_next = ch_base_reg + CH_STEP;
                            end
                            last_next = (x_next == X_MAX) && (y_next == Y_MAX) && (ch_next == CH_MAX);
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end

        if (load_first) begin
            x_next        = '0;
            y_next        = '0;
            ch_next       = '0;
            win_base_next = '0;
            row_base_next = '0;
            ch_base_next  = '0;
        end
    end

    // Each slice is a fixed offset from the next window base, so it stays put during stalls.
    genvar gi;
    generate
        for (gi = 0; gi < WIN * WIN; gi++) begin : g_slice
            localparam logic [ADDR_W-1:0] OFF = ADDR_W'((gi / WIN) * IMG_W + (gi % WIN));
            logic [ADDR_W-1:0] slice_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) slice_reg <= OFF;
                else        slice_reg <= win_base_next + OFF;
            end

            assign addr[gi*ADDR_W +: ADDR_W] = slice_reg;
        end
    endgenerate

    assign out_valid = valid_reg;
    assign out_x     = x_reg;
    assign out_y     = y_reg;
    assign out_ch    = ch_reg;
    assign last      = last_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_pool_window_addr_gen.sv
// Bench for pool_window_addr_gen: default 24x24 2x2/2 instance and a small
// 5x4 3x3/1 two-channel instance with a 5-cycle lead-in, against a loop-built window list.
module tb_pool_window_addr_gen;

    localparam int AW0 = 10;
    localparam int AW1 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start0, clear0, ready0, start1, clear1, ready1;
    logic valid0, last0, done0, valid1, last1, done1;
    logic [4*AW0-1:0] addr0;
    logic [9*AW1-1:0] addr1;
    logic [7:0] x0, y0, c0, x1, y1, c1;

    pool_window_addr_gen dut0 (
        .clk(clk), .reset(reset), .start(start0), .clear(clear0), .out_ready(ready0),
        .out_valid(valid0), .addr(addr0), .out_x(x0), .out_y(y0), .out_ch(c0),
        .last(last0), .done(done0)
    );

    pool_window_addr_gen #(
        .IMG_W(5), .IMG_H(4), .WIN(3), .STRIDE(1), .CHANNELS(2), .LEAD_IN(5), .ADDR_W(AW1)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start1), .clear(clear1), .out_ready(ready1),
        .out_valid(valid1), .addr(addr1), .out_x(x1), .out_y(y1), .out_ch(c1),
        .last(last1), .done(done1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int P_W[2]   = '{24, 5};
    int P_H[2]   = '{24, 4};
    int P_WIN[2] = '{2, 3};
    int P_S[2]   = '{2, 1};
    int P_C[2]   = '{1, 2};
    int P_AW[2]  = '{AW0, AW1};

    typedef struct {
        logic [63:0] a;
        int x;
        int y;
        int ch;
    } win_t;

    win_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected windows straight from the base-address formula, raster order x, y, ch.
    task automatic build_model(input int sel);
        int ow, oh, base;
        logic [63:0] a;
        win_t w;
        exp_q.delete();
        ow = (P_W[sel] - P_WIN[sel]) / P_S[sel] + 1;
        oh = (P_H[sel] - P_WIN[sel]) / P_S[sel] + 1;
        for (int ch = 0; ch < P_C[sel]; ch++)
            for (int y = 0; y < oh; y++)
                for (int x = 0; x < ow; x++) begin
                    base = ch * P_W[sel] * P_H[sel] + y * P_S[sel] * P_W[sel] + x * P_S[sel];
                    a = '0;
                    for (int r = 0; r < P_WIN[sel]; r++)
                        for (int c = 0; c < P_WIN[sel]; c++)
                            a = a | (64'(base + r * P_W[sel] + c) << ((r * P_WIN[sel] + c) * P_AW[sel]));
                    w.a = a; w.x = x; w.y = y; w.ch = ch;
                    exp_q.push_back(w);
                end
    endtask

    task automatic get_out(input int sel, output logic v, output logic l, output logic d,
                           output logic [63:0] a, output int x, output int y, output int ch);
        if (sel == 0) begin
            v = valid0; l = last0; d = done0; a = 64'(addr0);
            x = int'(x0); y = int'(y0); ch = int'(c0);
        end else begin
            v = valid1; l = last1; d = done1; a = 64'(addr1);
            x = int'(x1); y = int'(y1); ch = int'(c1);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic cl, input logic rd);
        if (sel == 0) begin start0 = st; clear0 = cl; ready0 = rd; end
        else          begin start1 = st; clear1 = cl; ready1 = rd; end
    endtask

    task automatic check_idle(input int sel, input logic exp_done, input bit coords);
        logic v, l, d;
        logic [63:0] a;
        int x, y, ch;
        get_out(sel, v, l, d, a, x, y, ch);
        check("idle_valid", 64'(v), 64'(0));
        check("idle_last", 64'(l), 64'(0));
        check("idle_done", 64'(d), 64'(exp_done));
        if (coords) begin
            build_model(sel);
            check("idle_x", 64'(x), 64'(0));
            check("idle_y", 64'(y), 64'(0));
            check("idle_ch", 64'(ch), 64'(0));
            check("idle_addr", a, exp_q[0].a);
        end
    endtask

    // Starts a traversal (caller is 1 time unit past a rising edge) and checks every cycle.
    // stop_at >= 0 returns while window stop_at is on the outputs.
    task automatic run_trav(input int sel, input int lead, input bit rnd, input int stop_at);
        int idx, stalls, k, n, bound;
        bit rd, st;
        logic v, l, d;
        logic [63:0] a;
        int x, y, ch;
        build_model(sel);
        n = exp_q.size();
        idx = 0; stalls = 0; k = 0;
        bound = lead + 4 * n + 50;
        drive(sel, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 1'b1);
        forever begin
            get_out(sel, v, l, d, a, x, y, ch);
            if (k < lead) begin
                check("lead_valid", 64'(v), 64'(0));
                check("lead_done", 64'(d), 64'(0));
            end else if (idx < n) begin
                check($sformatf("win%0d_valid", idx), 64'(v), 64'(1));
                check($sformatf("win%0d_addr", idx), a, exp_q[idx].a);
                check($sformatf("win%0d_x", idx), 64'(x), 64'(exp_q[idx].x));
                check($sformatf("win%0d_y", idx), 64'(y), 64'(exp_q[idx].y));
                check($sformatf("win%0d_ch", idx), 64'(ch), 64'(exp_q[idx].ch));
                check($sformatf("win%0d_last", idx), 64'(l), 64'(idx == n - 1));
                check($sformatf("win%0d_done", idx), 64'(d), 64'(0));
                if (idx == stop_at) begin
                    drive(sel, 1'b0, 1'b0, 1'b1);
                    return;
                end
            end else begin
                check("end_valid", 64'(v), 64'(0));
                check("end_done", 64'(d), 64'(1));
                check("done_time", 64'(k), 64'(lead + n + stalls));
                break;
            end
            if (k > bound) begin
                check("timeout_cycles", 64'(k), 64'(bound));
                break;
            end
            rd = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            st = rnd && (k >= lead) && ($urandom_range(0, 9) == 0);
            drive(sel, st, 1'b0, rd);
            if (k >= lead) begin
                if (rd) idx++;
                else    stalls++;
            end
            @(posedge clk); #1;
            k++;
        end
        $display("run sel=%0d lead=%0d windows=%0d stalls=%0d cycles=%0d", sel, lead, n, stalls, k);
        drive(sel, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(sel, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            @(posedge clk); #1;
            check_idle(sel, 1'b1, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b1);
        drive(1, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_idle(0, 1'b0, 1'b1);
        check_idle(1, 1'b0, 1'b1);
        $display("reset values checked");
        reset = 1'b1;
        @(posedge clk); #1;

        run_trav(0, 0, 1'b0, -1);
        run_trav(0, 0, 1'b1, -1);
        run_trav(1, 5, 1'b0, -1);
        run_trav(1, 5, 1'b1, -1);

        // reset asserted while window 40 is presented
        run_trav(0, 0, 1'b1, 40);
        reset = 1'b0;
        #1;
        check_idle(0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_idle(0, 1'b0, 1'b1);
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_idle(0, 1'b0, 1'b1);
        end
        $display("mid-run reset checked");
        run_trav(0, 0, 1'b0, -1);

        // clear mid-run
        run_trav(0, 0, 1'b0, 10);
        drive(0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b1);
        check_idle(0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_idle(0, 1'b0, 1'b1);
        $display("mid-run clear checked");

        // clear and start on the same edge
        for (int sel = 0; sel < 2; sel++) begin
            drive(sel, 1'b1, 1'b1, 1'b1);
            @(posedge clk); #1;
            drive(sel, 1'b0, 1'b0, 1'b1);
            check_idle(sel, 1'b0, 1'b1);
            repeat (6) begin
                @(posedge clk); #1;
                check_idle(sel, 1'b0, 1'b0);
            end
            $display("clear+start sel=%0d checked", sel);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
